// File: rtl/traffic_pkg.sv
// Shared light codes, phase encoding and segment constants for the traffic-light
// display stage.
package traffic_pkg;

  localparam logic [2:0] LIGHT_RED = 3'b100;
  localparam logic [2:0] LIGHT_YEL = 3'b010;
  localparam logic [2:0] LIGHT_GRN = 3'b001;

  typedef enum logic [1:0] {
    PH_ALLRED = 2'b00,
    PH_GREEN  = 2'b01,
    PH_YELLOW = 2'b10,
    PH_FAULT  = 2'b11
  } phase_t;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  // A legal pair always has one direction red; everything else is a fault.
  function automatic phase_t decode_phase(input logic [2:0] ns, input logic [2:0] ew);
    if (ns == LIGHT_RED && ew == LIGHT_RED)
      return PH_ALLRED;
    if ((ns == LIGHT_GRN && ew == LIGHT_RED) || (ns == LIGHT_RED && ew == LIGHT_GRN))
      return PH_GREEN;
    if ((ns == LIGHT_YEL && ew == LIGHT_RED) || (ns == LIGHT_RED && ew == LIGHT_YEL))
      return PH_YELLOW;
    return PH_FAULT;
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// BCD digit to active-low {g,f,e,d,c,b,a} segments; non-BCD codes show a dash.
module seg7_decode
  import traffic_pkg::*;
(
  input  logic [3:0] bcd_i,
  output logic [6:0] seg_o
);

  always_comb begin
    case (bcd_i)
      4'd0:    seg_o = 7'b1000000;
      4'd1:    seg_o = 7'b1111001;
      4'd2:    seg_o = 7'b0100100;
      4'd3:    seg_o = 7'b0110000;
      4'd4:    seg_o = 7'b0011001;
      4'd5:    seg_o = 7'b0010010;
      4'd6:    seg_o = 7'b0000010;
      4'd7:    seg_o = 7'b1111000;
      4'd8:    seg_o = 7'b0000000;
      4'd9:    seg_o = 7'b0010000;
      default: seg_o = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/light_countdown_display.sv
// Phase-change detector and per-second BCD countdown driving two 7-seg digits.
// Optional last-seconds blink is enabled with `define COUNTDOWN_BLINK_EN.
module light_countdown_display
  import traffic_pkg::*;
#(
  parameter int CLK_HZ     = 50_000_000,
  parameter int GREEN_SEC  = 6,
  parameter int YELLOW_SEC = 2,
  parameter int ALLRED_SEC = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] northsouth_light,
  input  logic [2:0] eastwest_light,
  output logic [6:0] hex_tens,
  output logic [6:0] hex_units,
  output logic [1:0] phase,
  output logic       fault
);

  if (CLK_HZ < 4) begin : g_bad_clk_hz
    $error("CLK_HZ must be >= 4");
  end
  if (GREEN_SEC < 1 || GREEN_SEC > 99) begin : g_bad_green
    $error("GREEN_SEC must be in 1..99");
  end
  if (YELLOW_SEC < 1 || YELLOW_SEC > 99) begin : g_bad_yellow
    $error("YELLOW_SEC must be in 1..99");
  end
  if (ALLRED_SEC < 1 || ALLRED_SEC > 99) begin : g_bad_allred
    $error("ALLRED_SEC must be in 1..99");
  end

  localparam int PW = $clog2(CLK_HZ);
  localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_HZ - 1);

  localparam logic [3:0] GRN_TENS = 4'(GREEN_SEC / 10);
  localparam logic [3:0] GRN_UNITS = 4'(GREEN_SEC % 10);
  localparam logic [3:0] YEL_TENS = 4'(YELLOW_SEC / 10);
  localparam logic [3:0] YEL_UNITS = 4'(YELLOW_SEC % 10);
  localparam logic [3:0] RED_TENS = 4'(ALLRED_SEC / 10);
  localparam logic [3:0] RED_UNITS = 4'(ALLRED_SEC % 10);

  logic [5:0]    prev_q, prev_d;
  logic [3:0]    tens_q, tens_d, units_q, units_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          valid_q, valid_d;
  phase_t        phase_q, phase_d, ph_now;
  logic          fault_q, fault_d;
  logic [6:0]    hex_tens_q, hex_tens_d, hex_units_q, hex_units_d;
  logic [6:0]    seg_tens, seg_units;
  logic          chg, tick, blink_off;

  assign ph_now = decode_phase(northsouth_light, eastwest_light);
  assign chg    = {northsouth_light, eastwest_light} != prev_q;
  assign tick   = presc_q == PRESC_MAX;

`ifdef COUNTDOWN_BLINK_EN
  localparam logic [PW-1:0] HALF_SEC = PW'(CLK_HZ / 2);
  assign blink_off = (tens_q == 4'd0) && (units_q != 4'd0) && (units_q <= 4'd3)
                   && (presc_q >= HALF_SEC);
`else
  assign blink_off = 1'b0;
`endif

  seg7_decode u_seg_tens  (.bcd_i(tens_q),  .seg_o(seg_tens));
  seg7_decode u_seg_units (.bcd_i(units_q), .seg_o(seg_units));

  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    prev_d  = {northsouth_light, eastwest_light};
    tens_d  = tens_q;
    units_d = units_q;
    presc_d = tick ? '0 : presc_q + PW'(1);
    valid_d = valid_q;
    phase_d = phase_q;
    fault_d = fault_q;

    if (chg) begin
      presc_d = '0;
      valid_d = 1'b1;
      phase_d = ph_now;
      fault_d = (ph_now == PH_FAULT);
      case (ph_now)
        PH_GREEN:  {tens_d, units_d} = {GRN_TENS, GRN_UNITS};
        PH_YELLOW: {tens_d, units_d} = {YEL_TENS, YEL_UNITS};
        PH_ALLRED: {tens_d, units_d} = {RED_TENS, RED_UNITS};
        default:   {tens_d, units_d} = 8'h00;
      endcase
    end else if (tick && !fault_q) begin
      // BCD borrow; 00 is a floor, not a wrap point.
      if (units_q != 4'd0) begin
        units_d = units_q - 4'd1;
      end else if (tens_q != 4'd0) begin
        tens_d  = tens_q - 4'd1;
        units_d = 4'd9;
      end
    end

    hex_tens_d  = seg_tens;
    hex_units_d = seg_units;
    if (!valid_q || (blink_off && !fault_q)) begin
      hex_tens_d  = SEG_BLANK;
      hex_units_d = SEG_BLANK;
    end else if (fault_q) begin
      hex_tens_d  = SEG_DASH;
      hex_units_d = SEG_DASH;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_q      <= 6'b0;
      tens_q      <= 4'd0;
      units_q     <= 4'd0;
      presc_q     <= '0;
      valid_q     <= 1'b0;
      phase_q     <= PH_ALLRED;
      fault_q     <= 1'b0;
      hex_tens_q  <= SEG_BLANK;
      hex_units_q <= SEG_BLANK;
    end else begin
      prev_q      <= prev_d;
      tens_q      <= tens_d;
      units_q     <= units_d;
      presc_q     <= presc_d;
      valid_q     <= valid_d;
      phase_q     <= phase_d;
      fault_q     <= fault_d;
      hex_tens_q  <= hex_tens_d;
      hex_units_q <= hex_units_d;
    end
  end

  assign hex_tens  = hex_tens_q;
  assign hex_units = hex_units_q;
  assign phase     = phase_q;
  assign fault     = fault_q;

endmodule

// File: tb/tb_light_countdown_display.sv
// Scoreboard bench: stimulus queues expected display state per cycle, a negedge
// monitor pops and compares.
module tb_light_countdown_display;

  localparam logic [6:0] BLK  = 7'h7F;
  localparam logic [6:0] DSH  = 7'b0111111;
  localparam logic [6:0] D0 = 7'h40, D1 = 7'h79, D2 = 7'h24, D3 = 7'h30;
  localparam logic [6:0] D4 = 7'h19, D5 = 7'h12, D6 = 7'h02;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] ns = 3'b001, ew = 3'b100;
  logic [6:0] hex_tens, hex_units;
  logic [1:0] phase;
  logic       fault;

  int cyc = 0;
  int checks = 0;
  int errors = 0;

  typedef struct packed {
    int       cyc;
    logic [6:0] tens;
    logic [6:0] units;
    logic [1:0] ph;
    logic     flt;
  } exp_t;

  exp_t  sb_q[$];
  string nm_q[$];
  exp_t  cur;
  string cur_name;

  light_countdown_display #(
    .CLK_HZ(10), .GREEN_SEC(6), .YELLOW_SEC(2), .ALLRED_SEC(2)
  ) dut (
    .clk(clk), .reset(reset),
    .northsouth_light(ns), .eastwest_light(ew),
    .hex_tens(hex_tens), .hex_units(hex_units),
    .phase(phase), .fault(fault)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_at(input int dc, input logic [6:0] t, input logic [6:0] u,
                           input logic [1:0] p, input logic f, input string nm);
    exp_t e;
    e.cyc = cyc + dc; e.tens = t; e.units = u; e.ph = p; e.flt = f;
    sb_q.push_back(e);
    nm_q.push_back(nm);
  endtask

  always @(negedge clk) begin
    while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
      cur      = sb_q.pop_front();
      cur_name = nm_q.pop_front();
      if (cur.cyc != cyc) begin
        check({cur_name, "_missed"}, cyc, cur.cyc);
      end else begin
        check({cur_name, "_tens"},  {25'd0, hex_tens},  {25'd0, cur.tens});
        check({cur_name, "_units"}, {25'd0, hex_units}, {25'd0, cur.units});
        check({cur_name, "_phase"}, {30'd0, phase},     {30'd0, cur.ph});
        check({cur_name, "_fault"}, {31'd0, fault},     {31'd0, cur.flt});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not end, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset with green lights already held; release must still load.
    step(2);
    expect_at(0, BLK, BLK, 2'b00, 1'b0, "reset");
    reset = 1'b0;
    expect_at(1,  BLK, BLK, 2'b01, 1'b0, "t1_load_edge");
    expect_at(2,  D0, D6, 2'b01, 1'b0, "t1_06");
    expect_at(11, D0, D6, 2'b01, 1'b0, "t1_pre_tick");
    expect_at(12, D0, D5, 2'b01, 1'b0, "t1_05");
    expect_at(32, D0, D3, 2'b01, 1'b0, "t1_03_first_half");
`ifdef COUNTDOWN_BLINK_EN
    expect_at(38, BLK, BLK, 2'b01, 1'b0, "t1_03_blink");
`else
    expect_at(38, D0, D3, 2'b01, 1'b0, "t1_03_steady");
`endif
    expect_at(61, D0, D1, 2'b01, 1'b0, "t1_01");
    expect_at(62, D0, D0, 2'b01, 1'b0, "t1_00");
    expect_at(92, D0, D0, 2'b01, 1'b0, "t1_00_hold");
    step(92);

    // All-red, then green, then yellow at count 03.
    ns = 3'b100; ew = 3'b100;
    expect_at(1, D0, D0, 2'b00, 1'b0, "t2_allred_edge");
    expect_at(2, D0, D2, 2'b00, 1'b0, "t2_allred_02");
    step(2);
    ns = 3'b001;
    expect_at(2, D0, D6, 2'b01, 1'b0, "t2_green_06");
    step(31);
    ns = 3'b010;
    expect_at(1,  D0, D3, 2'b10, 1'b0, "t2_03_at_load");
    expect_at(2,  D0, D2, 2'b10, 1'b0, "t2_reload_02");
    expect_at(11, D0, D2, 2'b10, 1'b0, "t2_pre_01");
    expect_at(12, D0, D1, 2'b10, 1'b0, "t2_01");
    step(20);

    // Light change coincides with a tick: load wins.
    ns = 3'b001;
    expect_at(1,  D0, D1, 2'b01, 1'b0, "t3_edge");
    expect_at(2,  D0, D6, 2'b01, 1'b0, "t3_load_no_dec");
    expect_at(11, D0, D6, 2'b01, 1'b0, "t3_pre_tick");
    expect_at(12, D0, D5, 2'b01, 1'b0, "t3_05");
    step(12);

    // Illegal pair, then legal all-red recovers.
    ns = 3'b011;
    expect_at(1,  D0, D5, 2'b11, 1'b1, "t4_fault_edge");
    expect_at(2,  DSH, DSH, 2'b11, 1'b1, "t4_dash");
    expect_at(14, DSH, DSH, 2'b11, 1'b1, "t4_dash_hold");
    step(14);
    ns = 3'b100;
    expect_at(1, DSH, DSH, 2'b00, 1'b0, "t4_clear_edge");
    expect_at(2, D0, D2, 2'b00, 1'b0, "t4_02");
    step(2);

    // Async reset at count 04, then no count until lights change.
    ns = 3'b001;
    expect_at(22, D0, D4, 2'b01, 1'b0, "t5_04");
    step(23);
    reset = 1'b1;
    ns = 3'b000; ew = 3'b000;
    expect_at(0, BLK, BLK, 2'b00, 1'b0, "t5_async_rst");
    step(2);
    reset = 1'b0;
    expect_at(1,  BLK, BLK, 2'b00, 1'b0, "t5_after_rel");
    expect_at(15, BLK, BLK, 2'b00, 1'b0, "t5_no_count");
    step(15);
    ns = 3'b100; ew = 3'b100;
    expect_at(2, D0, D2, 2'b00, 1'b0, "t5_restart_02");
    step(3);

    for (int i = 0; i < 50 && sb_q.size() > 0; i++) step(1);
    check("sb_drain", sb_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
